// File: rtl/bus_xfer_ctrl_if.sv
// bus_xfer_ctrl_if -- request handshake and system-bus signals of bus_xfer_ctrl.
//
// Handshake: a request transfers on a rising clk edge where req_valid=1 and
// req_ready=1. src_sel/dst_sel are sampled on that edge. The requester holds
// req_valid and the selects stable until that edge. The controller never
// withdraws req_ready without an accepting edge, except under reset.
//
// Signals:
//   req_valid          requester -> ctrl  request present
//   req_ready          ctrl -> requester  request accepted this cycle
//   src_sel, dst_sel   requester -> ctrl  register indices (0 AC,1 X,2 Y,3 SP,
//                                         4 PCL,5 PCH,6 DL,7 reserved)
//   systemBus_IN       bus -> ctrl        resolved system bus value
//   systemBusWrite_EN  ctrl -> regs       one-hot drive enables
//   systemBusRead_EN   ctrl -> regs       one-hot latch enables
//   xfer_data          ctrl -> requester  bus value captured by last transfer
//   done, err          ctrl -> requester  completion / rejection pulses
interface bus_xfer_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] src_sel;
  logic [2:0] dst_sel;
  logic [7:0] systemBus_IN;
  logic [7:0] systemBusWrite_EN;
  logic [7:0] systemBusRead_EN;
  logic [7:0] xfer_data;
  logic       done;
  logic       err;

  modport master (
    output req_valid, src_sel, dst_sel, systemBus_IN,
    input  req_ready, systemBusWrite_EN, systemBusRead_EN, xfer_data, done, err
  );

  modport slave (
    input  req_valid, src_sel, dst_sel, systemBus_IN,
    output req_ready, systemBusWrite_EN, systemBusRead_EN, xfer_data, done, err
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl -- sequences one register-to-register move over the shared
// system bus: the source drives for SETTLE_CYCLES cycles, then drives one more
// cycle while the destination latches, then drives one final cycle with the
// latch closed so the destination never captures an undriven bus.
//
// Parameters:
//   SETTLE_CYCLES  drive cycles before the latch cycle (legal 1..15)
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   bus        slave side of bus_xfer_ctrl_if (handshake, enables, results)
//   dbg_state  current FSM state (0 IDLE, 1 DRIVE, 2 LATCH, 3 RELEASE)
//
// Every output is a register. Illegal requests (reserved index or src==dst)
// are consumed in IDLE and answered with a one-cycle err pulse.
module bus_xfer_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_xfer_ctrl_if.slave         bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    LATCH   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [2:0] src_q;
  logic [2:0] dst_q;
  logic [3:0] settle_cnt;
  logic       illegal;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'(1) << idx;
  endfunction

  assign illegal = (bus.src_sel == 3'd7) || (bus.dst_sel == 3'd7) ||
                   (bus.src_sel == bus.dst_sel);

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      src_q                 <= '0;
      dst_q                 <= '0;
      settle_cnt            <= '0;
      bus.req_ready         <= 1'b0;
      bus.systemBusWrite_EN <= '0;
      bus.systemBusRead_EN  <= '0;
      bus.xfer_data         <= 8'h00;
      bus.done              <= 1'b0;
      bus.err               <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          // req_ready rises on the first edge spent in IDLE (also after reset).
          bus.req_ready         <= 1'b1;
          bus.systemBusWrite_EN <= '0;
          bus.systemBusRead_EN  <= '0;
          if (bus.req_valid && bus.req_ready) begin
            src_q <= bus.src_sel;
            dst_q <= bus.dst_sel;
            if (illegal) begin
              bus.err <= 1'b1;
            end else begin
              state                 <= DRIVE;
              settle_cnt            <= SETTLE_LOAD;
              bus.req_ready         <= 1'b0;
              bus.systemBusWrite_EN <= onehot(bus.src_sel);
            end
          end
        end
        DRIVE: begin
          // Counter reads SETTLE_CYCLES-1 in the first DRIVE cycle, so DRIVE
          // lasts exactly SETTLE_CYCLES cycles.
          if (settle_cnt == 4'd0) begin
            state                <= LATCH;
            bus.systemBusRead_EN <= onehot(dst_q);
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        LATCH: begin
          bus.xfer_data        <= bus.systemBus_IN;
          bus.systemBusRead_EN <= '0;
          state                <= RELEASE;
        end
        RELEASE: begin
          // Source is still driven in RELEASE; it drops together with done.
          bus.systemBusWrite_EN <= '0;
          bus.done              <= 1'b1;
          bus.req_ready         <= 1'b1;
          state                 <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl -- self-checking bench for bus_xfer_ctrl.
// dut  : SETTLE_CYCLES=1, table vectors, directed corners, random stress.
// dut4 : SETTLE_CYCLES=4, one directed cycle-accurate transfer.
// The system bus is modelled as the current source value while any drive
// enable is set, and 8'h00 otherwise.
module tb_bus_xfer_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_xfer_ctrl_if ifc();
  bus_xfer_ctrl_if ifc4();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state4;

  bus_xfer_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(ifc), .dbg_state(dbg_state)
  );
  bus_xfer_ctrl #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(ifc4), .dbg_state(dbg_state4)
  );

  logic [7:0] cur_val = 8'h00;
  assign ifc.systemBus_IN  = (|ifc.systemBusWrite_EN)  ? cur_val : 8'h00;
  assign ifc4.systemBus_IN = (|ifc4.systemBusWrite_EN) ? 8'h3C   : 8'h00;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_illegal(input logic [2:0] s, input logic [2:0] d);
    return (s == 3'd7) || (d == 3'd7) || (s == d);
  endfunction

  // ---------------- monitor: invariants + scoreboard pop ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("wr_onehot", ($countones(ifc.systemBusWrite_EN) <= 1), 1);
      check("rd_onehot", ($countones(ifc.systemBusRead_EN) <= 1), 1);
      if (ifc.systemBusRead_EN != 8'h00)
        check("rd_without_wr", (ifc.systemBusWrite_EN != 8'h00), 1);
      if (dbg_state == 2'd0)
        check("idle_enables", {ifc.systemBusWrite_EN, ifc.systemBusRead_EN}, 16'h0000);
      if (ifc.err) err_seen++;
      if (ifc.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("sb_xfer_data", ifc.xfer_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Presents one request, returns just after its accepting edge.
  task automatic present(input logic [2:0] s, input logic [2:0] d,
                         input logic [7:0] v, output logic was_done);
    int n = 0;
    @(negedge clk);
    while (!ifc.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    was_done = ifc.done;
    if (!ifc.req_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      ifc.src_sel   = s;
      ifc.dst_sel   = d;
      ifc.req_valid = 1'b1;
      if (is_illegal(s, d)) begin
        err_exp++;
      end else begin
        cur_val = v;
        exp_q.push_back(v);
      end
      @(posedge clk);
      #1;
      ifc.req_valid = 1'b0;
      ifc.src_sel   = 3'($urandom_range(0, 7));
      ifc.dst_sel   = 3'($urandom_range(0, 7));
    end
  endtask

  typedef struct {
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] val;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic wd;
    logic got;
    logic [7:0] prev;

    vecs[0] = '{3'd1, 3'd2, 8'h11, 1'b0};
    vecs[1] = '{3'd2, 3'd0, 8'h22, 1'b0};
    vecs[2] = '{3'd4, 3'd5, 8'h44, 1'b0};
    vecs[3] = '{3'd5, 3'd5, 8'h00, 1'b1};
    vecs[4] = '{3'd3, 3'd6, 8'h7E, 1'b0};
    vecs[5] = '{3'd0, 3'd7, 8'h00, 1'b1};
    vecs[6] = '{3'd6, 3'd3, 8'hC3, 1'b0};
    vecs[7] = '{3'd7, 3'd1, 8'h00, 1'b1};

    ifc.req_valid  = 1'b0;
    ifc.src_sel    = 3'd0;
    ifc.dst_sel    = 3'd0;
    ifc4.req_valid = 1'b0;
    ifc4.src_sel   = 3'd0;
    ifc4.dst_sel   = 3'd0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_wr", ifc.systemBusWrite_EN, 0);
    check("rst_rd", ifc.systemBusRead_EN, 0);
    check("rst_data", ifc.xfer_data, 0);
    check("rst_flags", {ifc.done, ifc.err, ifc.req_ready}, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    #1;
    check("ready_before_edge", ifc.req_ready, 0);
    @(negedge clk);
    check("ready_after_edge", ifc.req_ready, 1);

    // ---- SETTLE=1 basic transfer, cycle accurate: AC -> X, bus A5 ----
    present(3'd0, 3'd1, 8'hA5, wd);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("s1_wr_c%0d", k), ifc.systemBusWrite_EN, (k <= 3) ? 8'h01 : 8'h00);
      check($sformatf("s1_rd_c%0d", k), ifc.systemBusRead_EN, (k == 2) ? 8'h02 : 8'h00);
      check($sformatf("s1_done_c%0d", k), ifc.done, (k == 4));
      check($sformatf("s1_ready_c%0d", k), ifc.req_ready, (k >= 4));
      if (k == 4) check("s1_data", ifc.xfer_data, 8'hA5);
    end

    // ---- SETTLE=4: src 6 -> dst 2, bus 3C ----
    @(negedge clk);
    check("s4_ready", ifc4.req_ready, 1);
    ifc4.src_sel   = 3'd6;
    ifc4.dst_sel   = 3'd2;
    ifc4.req_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc4.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("s4_wr_c%0d", k), ifc4.systemBusWrite_EN, (k <= 6) ? 8'h40 : 8'h00);
      check($sformatf("s4_rd_c%0d", k), ifc4.systemBusRead_EN, (k == 5) ? 8'h04 : 8'h00);
      check($sformatf("s4_done_c%0d", k), ifc4.done, (k == 7));
      if (k == 7) check("s4_data", ifc4.xfer_data, 8'h3C);
    end

    // ---- table-driven vectors ----
    for (int i = 0; i < 8; i++) begin
      present(vecs[i].src, vecs[i].dst, vecs[i].val, wd);
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ifc.done || ifc.err) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("vec%0d_response", i), got, 1);
      check($sformatf("vec%0d_err", i), ifc.err, vecs[i].exp_err);
      check($sformatf("vec%0d_done", i), ifc.done, !vecs[i].exp_err);
      if (!vecs[i].exp_err) check($sformatf("vec%0d_data", i), ifc.xfer_data, vecs[i].val);
    end

    // ---- illegal pair: src==dst, then reserved src ----
    prev = ifc.xfer_data;
    present(3'd3, 3'd3, 8'h00, wd);
    @(negedge clk);
    check("ill1_err", ifc.err, 1);
    check("ill1_en", {ifc.systemBusWrite_EN, ifc.systemBusRead_EN}, 0);
    check("ill1_ready", ifc.req_ready, 1);
    present(3'd7, 3'd0, 8'h00, wd);
    @(negedge clk);
    check("ill2_err", ifc.err, 1);
    check("ill2_en", {ifc.systemBusWrite_EN, ifc.systemBusRead_EN}, 0);
    check("ill2_ready", ifc.req_ready, 1);
    check("ill_data_kept", ifc.xfer_data, prev);
    @(negedge clk);
    check("ill_err_one_cycle", ifc.err, 0);

    // ---- back-to-back: second accepted in the done cycle ----
    present(3'd1, 3'd4, 8'h9A, wd);
    present(3'd2, 3'd5, 8'h6B, wd);
    check("b2b_in_done_cycle", wd, 1);
    repeat (6) @(negedge clk);
    check("b2b_second_data", ifc.xfer_data, 8'h6B);

    // ---- reset during LATCH ----
    present(3'd0, 3'd1, 8'h5A, wd);
    @(posedge clk);
    #2;
    check("abort_in_latch", dbg_state, 2);
    reset = 1'b1;
    #1;
    check("abort_wr", ifc.systemBusWrite_EN, 0);
    check("abort_rd", ifc.systemBusRead_EN, 0);
    check("abort_data", ifc.xfer_data, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_done", ifc.done, 0);
      check("abort_no_resume", ifc.systemBusWrite_EN, 0);
    end
    present(3'd4, 3'd6, 8'hE7, wd);
    repeat (4) @(negedge clk);
    check("post_abort_done", ifc.done, 1);
    check("post_abort_data", ifc.xfer_data, 8'hE7);

    // ---- random stress: 1000 requests ----
    for (int i = 0; i < 1000; i++) begin
      present(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), wd);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    // ---- drain and final report ----
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("err_pulse_count", err_seen, err_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, is the number of cycles the source drives the system bus before the destination latches; legal range is 1-15.
REQ-002 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, is the asynchronous, active-high reset.
REQ-004 Port req_valid, input, 1, means a transfer request is present.
REQ-005 Port req_ready, output, 1, means the block accepts a request this cycle.
REQ-006 Port src_sel, input, 3, is the source register index: 0 AC, 1 X, 2 Y, 3 SP, 4 PCL, 5 PCH, 6 DL, 7 reserved.
REQ-007 Port dst_sel, input, 3, is the destination register index, with the same encoding as src_sel.
REQ-008 Port systemBus_IN, input, 8, is the resolved system bus value, sampled for capture.
REQ-009 Port systemBusWrite_EN, output, 8, is the one-hot set of drive enables; bit n enables register n onto the bus.
REQ-010 Port systemBusRead_EN, output, 8, is the one-hot set of latch enables; bit n makes register n load from the bus.
REQ-011 Port xfer_data, output, 8, is the bus value captured during the last completed transfer.
REQ-012 Port done, output, 1, is a one-cycle pulse at transfer completion.
REQ-013 Port err, output, 1, is a one-cycle pulse when an illegal request is rejected.

Function
REQ-014 The handshake shall accept a request on a rising edge where req_valid=1 and req_ready=1; src_sel and dst_sel shall be registered at acceptance.
REQ-015 req_ready shall be 1 only in IDLE.
REQ-016 The FSM shall have the states IDLE, DRIVE, LATCH, RELEASE.
REQ-017 A legal request accepted in IDLE shall move the FSM to DRIVE.
REQ-018 A request is illegal when src_sel==7, or dst_sel==7, or src_sel==dst_sel.
REQ-019 An illegal request shall be accepted, shall pulse err for the next cycle, shall leave the FSM in IDLE, and shall assert no enables.
REQ-020 DRIVE:
- systemBusWrite_EN[src]=1;
- the 4-bit settle counter loads SETTLE_CYCLES-1 on entry and decrements each cycle;
- the FSM goes to LATCH in the cycle after the counter reads 0.
REQ-021 LATCH lasts exactly one cycle:
- systemBusWrite_EN[src]=1 and systemBusRead_EN[dst]=1;
- xfer_data loads systemBus_IN on the rising edge that leaves LATCH;
- next state is RELEASE.
REQ-022 RELEASE lasts exactly one cycle:
- systemBusRead_EN=0 and systemBusWrite_EN[src] stays 1, so the destination never latches an undriven bus;
- next state is IDLE;
- done=1 in the first IDLE cycle after RELEASE.
REQ-023 Latency from the acceptance edge to done shall be SETTLE_CYCLES+3 cycles; with the default of 1, done is high in the 4th cycle after acceptance.
REQ-024 Back-to-back operation:
- a new request may be accepted in the same cycle done is high;
- the throughput limit is one transfer per SETTLE_CYCLES+3 cycles.
REQ-025 At most one bit of systemBusWrite_EN and at most one bit of systemBusRead_EN shall be 1 in any cycle.
REQ-026 Both enable buses shall be all-zero in IDLE.
REQ-027 All outputs shall be driven from registers; there shall be no combinational path from inputs to outputs.
REQ-028 req_valid and the select inputs shall be ignored outside IDLE.

Reset
REQ-029 While reset=1, regardless of clk:
- state=IDLE;
- systemBusWrite_EN=0 and systemBusRead_EN=0;
- xfer_data=8'h00;
- done=0, err=0, req_ready=0;
- settle counter=0.
REQ-030 req_ready shall rise on the first rising clk edge after reset deasserts.
REQ-031 Reset asserted mid-transfer shall clear all enables immediately, with no done pulse, and the aborted transfer shall not be resumed.

Verification
REQ-032 SETTLE_CYCLES=1, request src=0 (AC), dst=1 (X), bus modelled as 8'hA5 -> write_EN=8'h01 for 3 cycles; read_EN=8'h02 only in the 2nd of them; xfer_data=8'hA5; done 4 cycles after acceptance.
REQ-033 SETTLE_CYCLES=4, request src=6, dst=2, bus 8'h3C -> write_EN=8'h40 for 6 cycles; read_EN=8'h04 in the 5th of them; done at cycle 7.
REQ-034 Request src=3, dst=3; then src=7, dst=0 -> err pulses once per request; enables stay 0; xfer_data unchanged; req_ready stays 1.
REQ-035 Two requests held back-to-back on req_valid -> the second is accepted in the done cycle; enables never overlap between the two transfers; both capture their correct bus values.
REQ-036 Reset asserted in the LATCH cycle -> enables are 0 within the same cycle; no done pulse; xfer_data=8'h00; the next request completes normally.
REQ-037 Randomized requests over 1000 transfers -> the one-hot assertion holds in every cycle, and read_EN is never 1 unless write_EN is nonzero.
